pipelined_cla_addsub: RTL
=========================

Name: pipelined_cla_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor. It is the next generation of the team's 4-bit lookahead adder.
- Operands of WIDTH bits are split into STAGES equal slices. Each slice is resolved in one pipeline stage using 4-bit generate/propagate lookahead groups, and the inter-slice carry is registered between stages.
- Valid/ready handshakes on input and output let it sit in a streaming datapath between a producer and a consumer that may stall.

Parameters:
- WIDTH, 16: operand/sum width in bits. Must be a multiple of 4*STAGES.
- STAGES, 4: number of pipeline stages, which is also the latency in cycles. Slice width is CHUNK = WIDTH/STAGES. Minimum 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept an operand set this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry in. Used only when sub=0.
- sub  input  1  0: a+b+c_in; 1: a-b, computed as a+~b+1.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  WIDTH  result.
- c_out  output  1  carry out of MSB. For sub=1, 1 means no borrow (a>=b unsigned).
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  sum == 0.

Behaviour:
- Reset: while rst is high, all stage valid bits, out_valid, sum, c_out, ovf and zero are 0, asynchronously. in_ready is 1 once the valid bits are clear. In-flight operations are discarded; no stale result appears after release.
- Transfer rules:
  - Input transfer occurs when in_valid and in_ready are both 1 on a rising edge.
  - Output transfer occurs when out_valid and out_ready are both 1.
  - a, b, c_in and sub are sampled only on an input transfer.
- Stage pipeline:
  - Stage k (0..STAGES-1) holds a valid bit v[k].
  - Stage k advances when v[k]=0 or stage k+1 can accept. The last stage advances when out_valid=0 or out_ready=1.
  - in_ready = stage 0 can accept. It is a combinational function of the valid bits and out_ready only, never of in_valid.
- Throughput: 1 result per cycle when out_ready is held high.
- Latency: exactly STAGES cycles from input transfer to out_valid=1, with no stalls. STAGES=1 gives a result registered one cycle after accept.
- Stage k datapath:
  - Computes sum bits [k*CHUNK +: CHUNK] from the registered slice operands and the registered carry from stage k-1. Stage 0 uses c_in, or 1 when sub=1.
  - Within a slice, carries use 4-bit groups: g=a&b, p=a^b, with full lookahead expansion within each group and ripple between groups.
  - Operand bits not yet consumed travel forward in stage registers. Completed sum bits travel forward unchanged.
- Final flags: ovf and zero are derived in the last stage and registered with sum and c_out.
- Stall: a held output keeps sum, c_out, ovf and zero stable until accepted. Upstream stages fill; there is no loss or duplication. Pipeline capacity is STAGES results plus the output register.
- Simultaneous accept and drain when full: both occur in the same cycle, and occupancy is unchanged.
- Ordering: results leave in strict input order.
- Width arithmetic:
  - sum wraps modulo 2^WIDTH.
  - 0xFFFF+1 (WIDTH=16) gives sum=0, c_out=1.
  - Subtraction underflow wraps and gives c_out=0.
- sub is per-operation. Mixing add and sub in consecutive cycles is legal.

Test Plan:
1. WIDTH=16, STAGES=4: a=0xFFFF, b=0x0001, c_in=0, sub=0, out_ready=1 -> out_valid rises exactly 4 cycles after accept; sum=0x0000, c_out=1, zero=1, ovf=0.
2. sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, c_out=1, ovf=1. Then a=0x0003, b=0x0005 -> sum=0xFFFE, c_out=0, ovf=0.
3. Stream 16 back-to-back random add/sub ops with out_ready=1 -> in_ready stays 1 and one result per cycle after 4-cycle fill. Results are in order and match the model a+b+c_in or a-b.
4. Stream continuously and drop out_ready for 8 cycles -> in_ready falls after 5 ops held, output fields stay stable while stalled. All ops emerge once with no gaps after out_ready returns.
5. Assert rst with 3 ops in flight -> out_valid=0 immediately, before the next clock edge. After release, no result emerges until a new op is accepted, which returns after 4 cycles.
6. Constrained-random compare against a model for (WIDTH,STAGES) = (8,1), (8,2), (32,4), (32,8) with random in_valid/out_ready -> zero mismatches over 10k ops.

Source files
------------

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one CHUNK-bit slice is resolved per stage, carry registered between stages.
// Latency STAGES cycles; capacity STAGES+1 results; in_ready drops only when every stage and the output register are held.
module pipelined_cla_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);
    localparam int CHUNK  = WIDTH / STAGES;
    localparam int GROUPS = CHUNK / 4;

    // Returns {carry into slice MSB, carry out of slice, slice sum}.
    function automatic logic [CHUNK+1:0] slice_add(input logic [CHUNK-1:0] x,
                                                   input logic [CHUNK-1:0] y,
                                                   input logic ci);
        logic [CHUNK-1:0] g;
        logic [CHUNK-1:0] p;
        logic [CHUNK:0]   c;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        for (int q = 0; q < GROUPS; q++) begin
            int i;
            i = 4 * q;
            c[i+1] = g[i] | (p[i] & c[i]);
            c[i+2] = g[i+1] | (p[i+1] & g[i]) | (p[i+1] & p[i] & c[i]);
            c[i+3] = g[i+2] | (p[i+2] & g[i+1]) | (p[i+2] & p[i+1] & g[i])
                   | (p[i+2] & p[i+1] & p[i] & c[i]);
            c[i+4] = g[i+3] | (p[i+3] & g[i+2]) | (p[i+3] & p[i+2] & g[i+1])
                   | (p[i+3] & p[i+2] & p[i+1] & g[i])
                   | (p[i+3] & p[i+2] & p[i+1] & p[i] & c[i]);
        end
        return {c[CHUNK-1], c[CHUNK], p ^ c[CHUNK-1:0]};
    endfunction

    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] r_c;
    logic [WIDTH-1:0]  r_a [STAGES];
    logic [WIDTH-1:0]  r_b [STAGES];
    logic [WIDTH-1:0]  r_s [STAGES];
    logic              r_out_v;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic              r_ovf;
    logic              r_zero;

    logic [STAGES:0]   w_adv;
    logic [CHUNK+1:0]  w_res [STAGES];
    logic [WIDTH-1:0]  w_nxt [STAGES];

    // A stage may advance unless it and everything downstream is occupied and stalled.
    always_comb begin
        logic l_full;
        l_full        = r_out_v & ~out_ready;
        w_adv[STAGES] = ~l_full;
        for (int k = STAGES - 1; k >= 0; k--) begin
            l_full   = l_full & r_v[k];
            w_adv[k] = ~l_full;
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_res[k] = slice_add(r_a[k][k*CHUNK +: CHUNK], r_b[k][k*CHUNK +: CHUNK], r_c[k]);
            w_nxt[k] = r_s[k] | (WIDTH'(w_res[k][CHUNK-1:0]) << (k * CHUNK));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v     <= '0;
            r_c     <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end
            r_out_v <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            // Subtraction is folded in here so downstream stages only ever add.
            if (w_adv[0]) begin
                r_v[0] <= in_valid;
                if (in_valid) begin
                    r_a[0] <= a;
                    r_b[0] <= sub ? ~b : b;
                    r_c[0] <= sub | c_in;
                    r_s[0] <= '0;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (w_adv[k]) begin
                    r_v[k] <= r_v[k-1];
                    if (r_v[k-1]) begin
                        r_a[k] <= r_a[k-1];
                        r_b[k] <= r_b[k-1];
                        r_s[k] <= w_nxt[k-1];
                        r_c[k] <= w_res[k-1][CHUNK];
                    end
                end
            end
            if (w_adv[STAGES]) begin
                r_out_v <= r_v[STAGES-1];
                if (r_v[STAGES-1]) begin
                    r_sum  <= w_nxt[STAGES-1];
                    r_cout <= w_res[STAGES-1][CHUNK];
                    r_ovf  <= w_res[STAGES-1][CHUNK+1] ^ w_res[STAGES-1][CHUNK];
                    r_zero <= (w_nxt[STAGES-1] == '0);
                end
            end
        end
    end

    assign in_ready  = w_adv[0];
    assign out_valid = r_out_v;
    assign sum       = r_sum;
    assign c_out     = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule
